// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, latched request.
package load_store_unit_pkg;

  localparam int LSU_DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        off;
    logic [LSU_DW-1:0] wdata;
  } lsu_req_t;

  // The reserved size code behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane extraction for loads and lane merge for sub-word stores (little-endian lanes).
module lsu_lane_merge
  import load_store_unit_pkg::*;
#(
  parameter int DW = LSU_DW
) (
  input  logic [1:0]    size,
  input  logic [1:0]    offset,
  input  logic          sgn,
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] ld_data,
  output logic [DW-1:0] st_word
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{offset, 3'b000} +: 8];
  assign h = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = word;
    st_word = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{(DW-8){sgn & b[7]}}, b};
        st_word = word;
        st_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{(DW-16){sgn & h[15]}}, h};
        st_word = word;
        st_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU in front of a word-addressed RAM; sub-word stores do read-modify-write.
// Define LSU_ALIGN_CHECK_EN to turn misaligned half/word accesses into error responses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          resp_valid,
`ifdef LSU_ALIGN_CHECK_EN
  output logic          resp_err,
`endif
  output logic [DW-1:0] resp_rdata
);

  lsu_state_t    state;
  lsu_req_t      r;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] mrg_word;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] st_word;
  logic [1:0]    sz_in;
  logic [1:0]    off_in;

  assign sz_in = norm_size(req_size);

`ifdef LSU_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = (sz_in == SZ_HALF && req_addr[0]) ||
                    (sz_in == SZ_WORD && req_addr[1:0] != 2'b00);
  assign off_in   = req_addr[1:0];
`else
  // Offending low bits are dropped so the access lands on the enclosing lane.
  assign off_in = (sz_in == SZ_BYTE) ? req_addr[1:0] :
                  (sz_in == SZ_HALF) ? {req_addr[1], 1'b0} : 2'b00;
`endif

  // In READ the merge base is the live RAM word; afterwards the captured copy.
  assign mrg_word = (state == ST_READ) ? mem_rd : rd_q;

  lsu_lane_merge #(.DW(DW)) u_merge (
    .size    (r.size),
    .offset  (r.off),
    .sgn     (r.sgn),
    .word    (mrg_word),
    .wdata   (r.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      resp_err   <= 1'b0;
`endif
      r          <= '0;
      rd_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      resp_err   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r         <= '{we: req_we, size: sz_in, sgn: req_signed, off: off_in, wdata: req_wdata};
            mem_addr  <= {2'b00, req_addr[AW-1:2]};
            mem_wd    <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
            if (misaligned_go(misalign)) state <= ST_ERR;
            else
`endif
            if (req_we && sz_in == SZ_WORD) begin
              state  <= ST_WRITE;
              mem_we <= 1'b1;
            end else begin
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          rd_q <= mem_rd;
          if (r.we) begin
            state  <= ST_WRITE;
            mem_we <= 1'b1;
            mem_wd <= st_word;
          end else begin
            state  <= ST_RESP;
          end
        end
        ST_WRITE: begin
          mem_we <= 1'b0;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= r.we ? '0 : ld_data;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
`ifdef LSU_ALIGN_CHECK_EN
        ST_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
`endif
        default: begin
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic misaligned_go(input logic m);
    return m;
  endfunction
`endif

endmodule
